// File: rtl/tff_arb_pkg.sv
// Shared types and constants for the toggle-bank arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tff_arb_pkg;

  // Arbiter FSM: idle, one grant cycle, one mandatory gap cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops; each bit toggles when its t bit is set at the edge.
// Latency: q reflects t/clr one cycle after they are sampled.
// Backpressure: none; t and clr are applied unconditionally.
// Ports: clk, rst (sync, active-high), clr (sync clear), t[WIDTH] (toggle enables), q[WIDTH] (state).
module tff_bank
  import tff_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting requesters the right to XOR their mask into a shared T-FF bank.
// Latency: gnt one cycle after req is sampled in IDLE; q/toggle_cnt update on the edge leaving APPLY.
// Backpressure: at most one grant per 3 cycles; requesters hold req until granted, en low blocks new grants.
// Ports: clk, rst (sync, active-high), en, clr, req[N_REQ], mask[N_REQ*WIDTH] (slice i = requester i),
//        gnt[N_REQ] (one-hot pulse), q[WIDTH], busy, toggle_cnt[16].
module tff_toggle_arbiter
  import tff_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] mask,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [CNT_W-1:0]       toggle_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    win_comb;
  logic [PW-1:0]    win_hi;
  logic [PW-1:0]    win_lo;
  logic             hi_found;
  logic             lo_found;
  logic [WIDTH-1:0] mask_win;
  logic [WIDTH-1:0] t_vec;
  logic             bank_clr;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: the lowest set req at or above ptr wins; if none, the
  // lowest set req overall (the wrap-around case). The loop runs downward so
  // the final assignment is the lowest index.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo   = PW'(i);
        lo_found = 1'b1;
        if (PW'(i) >= ptr) begin
          win_hi   = PW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_comb = hi_found ? win_hi : win_lo;
  end

  // Mask slice of the latched winner.
  always_comb begin
    mask_win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) begin
        mask_win = mask[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic; clr in IDLE pre-empts arbitration for that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clr && en && lo_found) state_nxt = APPLY;
      APPLY:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      win <= '0;
      gnt <= '0;
      cnt <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && state_nxt == APPLY) begin
        win <= win_comb;
        gnt <= N_REQ'(1) << win_comb;
      end
      if (state == APPLY) begin
        cnt <= cnt + 1'b1;
        ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  // The toggle lands on the edge leaving APPLY; clr is honoured only in IDLE.
  // Reset inside the bank beats t, so an aborted grant never toggles q.
  assign t_vec    = (state == APPLY) ? mask_win : '0;
  assign bank_clr = clr && (state == IDLE);

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .clr (bank_clr),
    .t   (t_vec),
    .q   (q)
  );

  assign busy       = (state != IDLE);
  assign toggle_cnt = cnt;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
module tb_tff_toggle_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         clr;
  logic [N-1:0] req;
  logic [N*W-1:0] mask;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic         busy;
  logic [15:0]  toggle_cnt;

  always #5 clk = ~clk;

  tff_toggle_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .req        (req),
    .mask       (mask),
    .gnt        (gnt),
    .q          (q),
    .busy       (busy),
    .toggle_cnt (toggle_cnt)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  vec_t tv[10];
  int   checks = 0;
  int   errors = 0;
  int   first_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] qv, input logic [15:0] c);
    exp_t e;
    e.gnt = g; e.q = qv; e.cnt = c;
    sb_q.push_back(e);
  endtask

  // Step until every queued grant has been observed; each requester drops
  // its req once it sees its grant. Returns with the FSM back in IDLE.
  task automatic run_sb(input int budget, input bit spacing);
    exp_t e;
    int   n;
    int   last;
    n = 0;
    last = -1;
    while (sb_q.size() > 0 && n < budget) begin
      step();
      n++;
      if (gnt != '0) begin
        e = sb_q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        if (last < 0) first_lat = n;
        if (spacing && last >= 0) check("gnt_spacing", 32'(n - last), 32'd3);
        last = n;
        req = req & ~gnt;
        step();
        n++;
        check("q_after_apply", 32'(q), 32'(e.q));
        check("cnt_after_apply", 32'(toggle_cnt), 32'(e.cnt));
        check("busy_in_gap", 32'(busy), 32'd1);
      end
    end
    if (sb_q.size() > 0) begin
      check("grant_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mask = {8'h3C, 8'h00, 8'hF0, 8'h0F};
    // Table: req bits added this step, expected grant, q and count after it.
    tv[0] = '{4'b0001, 4'b0001, 8'h0F, 16'd1};
    tv[1] = '{4'b0001, 4'b0001, 8'h00, 16'd2};
    tv[2] = '{4'b1000, 4'b1000, 8'h3C, 16'd3};
    tv[3] = '{4'b0100, 4'b0100, 8'h3C, 16'd4};
    tv[4] = '{4'b0011, 4'b0001, 8'h33, 16'd5};
    tv[5] = '{4'b0000, 4'b0010, 8'hC3, 16'd6};
    tv[6] = '{4'b1111, 4'b0100, 8'hC3, 16'd7};
    tv[7] = '{4'b0000, 4'b1000, 8'hFF, 16'd8};
    tv[8] = '{4'b0000, 4'b0001, 8'hF0, 16'd9};
    tv[9] = '{4'b0000, 4'b0010, 8'h00, 16'd10};

    // Reset state, and reset dominating live requests.
    rst = 1'b1; en = 1'b1; clr = 1'b0; req = 4'b1111;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_cnt", 32'(toggle_cnt), 32'd0);
    req = '0;
    rst = 1'b0;

    // Table-driven grants.
    for (int i = 0; i < 10; i++) begin
      req = req | tv[i].req;
      push(tv[i].gnt, tv[i].q, tv[i].cnt);
      run_sb(20, 1'b0);
    end

    // All four requesting from ptr=0: order 0,1,2,3, three cycles apart.
    do_reset();
    req = 4'b1111;
    push(4'b0001, 8'h0F, 16'd1);
    push(4'b0010, 8'hFF, 16'd2);
    push(4'b0100, 8'hFF, 16'd3);
    push(4'b1000, 8'hC3, 16'd4);
    first_lat = -1;
    run_sb(40, 1'b1);
    check("first_latency", 32'(first_lat), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);

    // Same requester twice with 0xA5.
    do_reset();
    mask = {8'h3C, 8'h00, 8'hF0, 8'hA5};
    check("a5_start", 32'(q), 32'd0);
    req = 4'b0001;
    push(4'b0001, 8'hA5, 16'd1);
    run_sb(10, 1'b0);
    req = 4'b0001;
    push(4'b0001, 8'h00, 16'd2);
    run_sb(10, 1'b0);

    // clr beats arbitration in IDLE; clr in APPLY/GAP is ignored.
    do_reset();
    mask = {8'h3C, 8'h00, 8'hF0, 8'h0F};
    req = 4'b1000;
    push(4'b1000, 8'h3C, 16'd1);
    run_sb(10, 1'b0);
    clr = 1'b1; req = 4'b0010;
    step();
    check("clr_no_gnt", 32'(gnt), 32'd0);
    check("clr_q", 32'(q), 32'd0);
    clr = 1'b0;
    step();
    check("gnt_after_clr", 32'(gnt), 32'b0010);
    req = '0; clr = 1'b1;
    step();
    check("clr_ignored_apply", 32'(q), 32'hF0);
    check("clr_ignored_cnt", 32'(toggle_cnt), 32'd2);
    step();
    check("clr_ignored_gap", 32'(q), 32'hF0);
    step();
    check("clr_in_idle", 32'(q), 32'd0);
    clr = 1'b0;

    // Reset during APPLY: no toggle, no count, ptr back to 0.
    do_reset();
    req = 4'b0001;
    push(4'b0001, 8'h0F, 16'd1);
    run_sb(10, 1'b0);
    req = 4'b0010;
    step();
    check("pre_abort_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    step();
    check("abort_q", 32'(q), 32'd0);
    check("abort_cnt", 32'(toggle_cnt), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0; req = 4'b0011;
    push(4'b0001, 8'h0F, 16'd1);
    run_sb(10, 1'b0);
    req = '0;

    // en low blocks grants; dropping en mid-grant does not abort it.
    do_reset();
    mask = {8'h3C, 8'h81, 8'hF0, 8'h0F};
    en = 1'b0; req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("en_low_gnt", 32'(gnt), 32'd0);
    end
    en = 1'b1;
    step();
    check("en_latency", 32'(gnt), 32'b0100);
    en = 1'b0; req = '0;
    step();
    check("en_drop_q", 32'(q), 32'h81);
    check("en_drop_cnt", 32'(toggle_cnt), 32'd1);
    step();
    step();
    check("en_drop_idle_gnt", 32'(gnt), 32'd0);
    check("en_drop_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_toggle_arbiter.md
TFF_TOGGLE_ARBITER -- requirements
Module: tff_toggle_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, number of T flip-flops in the shared toggle bank.
REQ-003 Timing: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  arbitration enable; low blocks new grants.
REQ-007 clr  input  1  synchronous clear request for the toggle bank.
REQ-008 req  input  N_REQ  per-requester toggle request, level, held until granted.
REQ-009 mask  input  N_REQ*WIDTH  per-requester toggle mask; slice i is bits [i*WIDTH +: WIDTH].
REQ-010 gnt  output  N_REQ  one-hot registered grant, one-cycle pulse.
REQ-011 q  output  WIDTH  current toggle-bank state.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 toggle_cnt  output  16  count of grants issued since reset.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, APPLY, GAP.
REQ-015 In IDLE, if clr=1, the next edge SHALL set q to 0 and stay in IDLE; clr SHALL take priority over arbitration.
REQ-016 In IDLE, with clr=0, en=1 and req!=0, the next edge SHALL latch the round-robin winner and enter APPLY.
REQ-017 Winner = first set req bit searching upward from pointer ptr, wrapping from N_REQ-1 to 0.
REQ-018 In APPLY, gnt SHALL be one-hot at the winner for exactly one cycle; otherwise gnt SHALL be 0.
REQ-019 On the edge leaving APPLY: q <= q XOR mask[winner]; toggle_cnt += 1 (wraps 0xFFFF->0); ptr <= (winner+1) mod N_REQ; go to GAP.
REQ-020 GAP SHALL last one cycle and then return to IDLE unconditionally; the requester SHALL deassert req on the edge after seeing gnt.
REQ-021 Maximum throughput SHALL be one grant per 3 cycles; latency from req rising in IDLE to gnt SHALL be 1 cycle.
REQ-022 clr in APPLY or GAP SHALL be ignored; only clr sampled in IDLE has effect.
REQ-023 en deasserted in APPLY or GAP SHALL NOT abort the in-flight grant.
REQ-024 A grant with an all-zero mask slice SHALL still count, move ptr and leave q unchanged.
REQ-025 Each q bit SHALL act as a T flip-flop: it toggles only when its t bit is 1 at the edge.
REQ-026 busy SHALL equal (state != IDLE), combinational from the state register.

Reset
REQ-027 With rst=1 at an edge: state=IDLE, ptr=0, q=0, gnt=0, toggle_cnt=0, busy=0.
REQ-028 Reset SHALL take priority over clr, en and req, including mid-APPLY; an aborted grant SHALL NOT toggle q or count.

Structure
REQ-029 Package tff_arb_pkg SHALL hold the state enum (IDLE, APPLY, GAP), default N_REQ/WIDTH and the toggle_cnt width constant.
REQ-030 Sub-module tff_bank (clk, rst, clr, t[WIDTH], q[WIDTH]) SHALL implement the flip-flop bank; the arbiter drives t=mask[winner] only on the APPLY cycle.

Verification
REQ-031 Reset, then req=0001, mask0=0x0F -> gnt=0001 one cycle later; q=0x0F after APPLY; toggle_cnt=1.
REQ-032 req=1111 held and each requester dropping after its grant -> grant order 0,1,2,3; gnts 3 cycles apart.
REQ-033 Same requester granted twice with mask 0xA5 -> q goes 0x00, 0xA5, 0x00.
REQ-034 clr=1 and req=0010 together in IDLE with q=0x3C -> q=0x00, no gnt that cycle; grant to 1 follows.
REQ-035 rst asserted during APPLY -> q, toggle_cnt and ptr are 0 next cycle; state IDLE; no toggle applied.
REQ-036 en=0 with req=0100 -> no gnt for 10 cycles; en=1 -> gnt=0100 after 1 cycle.
